writeback_queue: RTL and testbench
==================================

# writeback_queue

Write-side front end for the 32x32 register file: owns the regfile's single write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`) and arbitrates between the in-order pipeline writeback and out-of-order multi-cycle (mult/div) results. Multi-cycle results are buffered in a small FIFO and drained into write-port slots the pipeline leaves idle. Reports pending-write hazards to decode, and optionally bypasses queued data.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, 2..16.
- `STARVE_LIMIT`, 8: consecutive blocked drain cycles before `pipe_stall` is raised.

- `clock`  in  1  single clock, all state on rising edge.
- `ctrl_reset`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  pipeline writeback valid; never back-pressured.
- `wb_reg`  in  5  pipeline destination register.
- `wb_data`  in  32  pipeline result.
- `md_valid`  in  1  mult/div result valid.
- `md_reg`  in  5  mult/div destination.
- `md_data`  in  32  mult/div result.
- `md_ready`  out  1  FIFO can accept; transfer when `md_valid & md_ready`.
- `query_regA`, `query_regB`  in  5 each  decode-stage source registers.
- `pending_A`, `pending_B`  out  1 each  a live queued write targets that register.
- `bypass_valid_A`, `bypass_valid_B`  out  1 each  bypass data available (macro-gated).
- `bypass_data_A`, `bypass_data_B`  out  32 each  youngest live queued value.
- `pipe_stall`  out  1  request upstream bubble so the queue can drain.
- `ctrl_writeEnable`  out  1  to regfile.
- `ctrl_writeReg`  out  5  to regfile.
- `data_writeReg`  out  32  to regfile.

## Operation
- Pipeline write "live" when `wb_valid & wb_reg != 0`; it always owns the write port that cycle (combinational pass-through).
- Otherwise, if the FIFO head is live, it drives the write port and pops; if the head is dead (killed), it pops with `ctrl_writeEnable = 0`.
- Enqueue when `md_valid & md_ready`; `md_reg == 0` completes the handshake but stores nothing.
- `md_ready = !full`, using registered occupancy; simultaneous pop does not admit an extra entry when full.
- Kill rule: a live pipeline write to R clears the live bit of every entry holding R present at the start of that cycle. An entry enqueued in the same cycle is newer and is not killed.
- `pending_X` = any live entry with reg == `query_regX`, where `query_regX != 0`. It excludes the entry being enqueued this cycle.
- Starvation counter: increments each cycle the FIFO holds a live entry and the pipeline owns the port; clears on any pop or when the FIFO is empty. `pipe_stall = (count >= STARVE_LIMIT)`.

## Timing
- Pipeline path: zero latency, write lands at the same edge.
- Queue path: entry enqueued at edge N is written at edge N+1 at the earliest.
- FIFO order is strictly preserved.
- Reset: FIFO empty, all live bits 0, counter 0, `md_ready = 1`. All write, pending and bypass outputs and `pipe_stall` are 0 while `ctrl_reset` is high, including pipeline pass-through.
- Reset mid-operation discards queued entries; no partial writes.
- Pointers wrap modulo `DEPTH`; full/empty is distinguished by an extra pointer bit.

## Configuration
- `WBQ_BYPASS_EN` defined: `bypass_valid_X = pending_X`, and `bypass_data_X` comes from the youngest live matching entry (priority from tail backward).
- Not defined: bypass outputs are tied to 0 and decode must stall on `pending_X`.

## Structure
- Shared package `wbq_pkg`: entry typedef {live, reg[4:0], data[31:0]}, `REG_ZERO` constant, and the pointer-width function `$clog2(DEPTH)+1`.
- One sub-module: `wbq_match`, which performs the per-entry register compare and youngest-match priority select. It is instantiated twice, for ports A and B.

## Test plan
- Idle pipeline; md writes R5=0x1234 at edge 0 -> regfile write R5=0x1234 at edge 1; `pending` for R5 is high during cycle 1 only.
- Four md enqueues while `wb_valid` is high every cycle -> `md_ready` drops after the 4th; `pipe_stall` rises after 8 blocked cycles; first idle pipeline cycle pops the head in FIFO order.
- Queue holds R7=0xAAAA; pipeline writes R7=0xBBBB -> entry killed, head pops with no write, and R7 ends at 0xBBBB.
- Queue holds R3=1 then R3=2 with `WBQ_BYPASS_EN` defined; `query_regA = 3` -> `bypass_data_A = 2`. Without the macro, the bypass output is 0 and `pending_A = 1`.
- md result to R0 and pipeline write to R0 -> handshake completes, no write, nothing enqueued.
- Three entries queued, `ctrl_reset` pulsed for one cycle -> no writes afterward, `md_ready = 1`, all pending outputs 0.

Source files
------------

// File: rtl/wbq_pkg.sv
// wbq_pkg: shared entry type, register-zero constant and pointer width helper
package wbq_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        live;
        logic [4:0]  dst;
        logic [31:0] data;
    } entry_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wbq_match.sv
// wbq_match: per-entry register compare with youngest-live-match select
module wbq_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = ptr_width(DEPTH) - 1
) (
    input  entry_t [DEPTH-1:0] entries,
    input  logic [AW-1:0]      tail,
    input  logic [4:0]         query,
    output logic               hit,
    output logic [31:0]        data
);

    logic [AW-1:0] idx;

    // walk from the oldest slot to the youngest so the youngest match wins
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail + AW'(k);
            if (query != REG_ZERO && entries[idx].live && entries[idx].dst == query) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: regfile write-port arbiter with mult/div FIFO; optional bypass via WBQ_BYPASS_EN
module writeback_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic [4:0]  query_regA,
    input  logic [4:0]  query_regB,
    output logic        pending_A,
    output logic        pending_B,
    output logic        bypass_valid_A,
    output logic        bypass_valid_B,
    output logic [31:0] bypass_data_A,
    output logic [31:0] bypass_data_B,
    output logic        pipe_stall,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    entry_t [DEPTH-1:0] mem;
    entry_t             head;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      starve;
    logic               wb_live, empty, full, pop, enq, any_live, head_write, hit_a, hit_b;
    logic [31:0]        data_a, data_b;

    assign wb_live    = !ctrl_reset && wb_valid && wb_reg != REG_ZERO;
    assign empty      = wr_ptr == rd_ptr;
    assign full       = wr_ptr == {~rd_ptr[PW-1], rd_ptr[AW-1:0]};
    assign head       = mem[rd_ptr[AW-1:0]];
    assign pop        = !ctrl_reset && !wb_live && !empty;
    assign head_write = pop && head.live;
    assign enq        = !ctrl_reset && md_valid && !full && md_reg != REG_ZERO;
    assign md_ready   = !full;

    assign ctrl_writeEnable = wb_live || head_write;
    assign ctrl_writeReg    = wb_live ? wb_reg : head_write ? head.dst : REG_ZERO;
    assign data_writeReg    = wb_live ? wb_data : head_write ? head.data : '0;
    assign pipe_stall       = !ctrl_reset && starve >= CW'(STARVE_LIMIT);

    // any queued write still live, for the starvation counter
    always_comb begin
        any_live = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_live |= mem[i].live;
    end

    // kill entries overwritten by the pipeline, retire the head, admit the new result
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) if (wb_live && mem[i].dst == wb_reg) mem[i].live <= 1'b0;
            if (pop) begin
                mem[rd_ptr[AW-1:0]].live <= 1'b0;
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq) begin
                mem[wr_ptr[AW-1:0]] <= '{live: 1'b1, dst: md_reg, data: md_data};
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    // count cycles a live entry waits behind the pipeline; saturates at the limit
    always_ff @(posedge clock) begin
        if (ctrl_reset || pop || empty) starve <= '0;
        else if (any_live && wb_live && starve < CW'(STARVE_LIMIT)) starve <= starve + CW'(1);
    end

    wbq_match #(.DEPTH(DEPTH)) u_match_a (
        .entries(mem), .tail(wr_ptr[AW-1:0]), .query(query_regA), .hit(hit_a), .data(data_a)
    );

    wbq_match #(.DEPTH(DEPTH)) u_match_b (
        .entries(mem), .tail(wr_ptr[AW-1:0]), .query(query_regB), .hit(hit_b), .data(data_b)
    );

    assign pending_A = !ctrl_reset && hit_a;
    assign pending_B = !ctrl_reset && hit_b;

`ifdef WBQ_BYPASS_EN
    assign bypass_valid_A = pending_A;
    assign bypass_valid_B = pending_B;
    assign bypass_data_A  = pending_A ? data_a : '0;
    assign bypass_data_B  = pending_B ? data_b : '0;
`else
    logic unused_bypass;
    assign unused_bypass  = ^{data_a, data_b};
    assign bypass_valid_A = 1'b0;
    assign bypass_valid_B = 1'b0;
    assign bypass_data_A  = '0;
    assign bypass_data_B  = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: queue-model scoreboard plus directed scenarios for writeback_queue
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        wb_valid, md_valid, md_ready;
    logic [4:0]  wb_reg, md_reg, query_regA, query_regB, ctrl_writeReg;
    logic [31:0] wb_data, md_data, bypass_data_A, bypass_data_B, data_writeReg;
    logic        pending_A, pending_B, bypass_valid_A, bypass_valid_B, pipe_stall, ctrl_writeEnable;

    int pass = 0;
    int total = 0;

    typedef struct {
        bit          live;
        logic [4:0]  r;
        logic [31:0] d;
    } ment_t;

    ment_t       q[$];
    int          cnt_m = 0;
    logic [31:0] obs_rf [32];

    writeback_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
        .query_regA(query_regA), .query_regB(query_regB),
        .pending_A(pending_A), .pending_B(pending_B),
        .bypass_valid_A(bypass_valid_A), .bypass_valid_B(bypass_valid_B),
        .bypass_data_A(bypass_data_A), .bypass_data_B(bypass_data_B),
        .pipe_stall(pipe_stall),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                          input logic mv, input logic [4:0] mr, input logic [31:0] md);
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        md_valid = mv; md_reg = mr; md_data = md;
    endtask

    // registers as written by the DUT, for end-state checks
    initial for (int i = 0; i < 32; i++) obs_rf[i] = '0;
    always @(posedge clock) if (ctrl_writeEnable) obs_rf[ctrl_writeReg] <= data_writeReg;

    // reference model: ordered list of pending writes and a wait counter
    always @(posedge clock) begin
        int n;
        bit wbl, popm, anyl;
        ment_t e;
        n = q.size();
        if (ctrl_reset) begin
            q.delete();
            cnt_m = 0;
        end else begin
            wbl  = wb_valid && wb_reg != 0;
            popm = !wbl && n > 0;
            anyl = 0;
            foreach (q[i]) if (q[i].live) anyl = 1;
            if (popm || n == 0) cnt_m = 0;
            else if (anyl && wbl) cnt_m++;
            if (wbl) foreach (q[i]) if (q[i].r == wb_reg) q[i].live = 0;
            if (popm) void'(q.pop_front());
            if (md_valid && n < DEPTH && md_reg != 0) begin
                e.live = 1; e.r = md_reg; e.d = md_data;
                q.push_back(e);
            end
        end
    end

    // compare every output with the model each cycle
    always @(negedge clock) begin
        logic        ewe, pa, pb;
        logic [4:0]  er;
        logic [31:0] ed, da, db;
        ewe = 0; er = 0; ed = 0;
        if (!ctrl_reset && wb_valid && wb_reg != 0) begin
            ewe = 1; er = wb_reg; ed = wb_data;
        end else if (!ctrl_reset && q.size() > 0 && q[0].live) begin
            ewe = 1; er = q[0].r; ed = q[0].d;
        end
        pa = 0; pb = 0; da = 0; db = 0;
        foreach (q[i]) begin
            if (!ctrl_reset && query_regA != 0 && q[i].live && q[i].r == query_regA) begin pa = 1; da = q[i].d; end
            if (!ctrl_reset && query_regB != 0 && q[i].live && q[i].r == query_regB) begin pb = 1; db = q[i].d; end
        end
        check("cmp_we", ctrl_writeEnable, ewe);
        check("cmp_reg", ctrl_writeReg, er);
        check("cmp_data", data_writeReg, ed);
        check("cmp_ready", md_ready, q.size() < DEPTH);
        check("cmp_pendA", pending_A, pa);
        check("cmp_pendB", pending_B, pb);
        check("cmp_stall", pipe_stall, !ctrl_reset && cnt_m >= LIMIT);
`ifdef WBQ_BYPASS_EN
        check("cmp_bvA", bypass_valid_A, pa);
        check("cmp_bvB", bypass_valid_B, pb);
        check("cmp_bdA", bypass_data_A, da);
        check("cmp_bdB", bypass_data_B, db);
`else
        check("cmp_bvA", bypass_valid_A, 0);
        check("cmp_bvB", bypass_valid_B, 0);
        check("cmp_bdA", bypass_data_A, 0);
        check("cmp_bdB", bypass_data_B, 0);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        ctrl_reset = 1;
        set_in(1, 9, 32'h99, 0, 0, 0);
        query_regA = 0; query_regB = 0;
        tick(); #1;
        check("rst_we", ctrl_writeEnable, 0);
        check("rst_ready", md_ready, 1);
        check("rst_stall", pipe_stall, 0);

        // single md result through an idle pipeline
        tick(); ctrl_reset = 0; set_in(0, 0, 0, 1, 5, 32'h1234); query_regA = 5; #1;
        check("t1_pend_enq", pending_A, 0);
        check("t1_we_enq", ctrl_writeEnable, 0);
        tick(); set_in(0, 0, 0, 0, 0, 0); #1;
        check("t1_we", ctrl_writeEnable, 1);
        check("t1_reg", ctrl_writeReg, 5);
        check("t1_data", data_writeReg, 32'h1234);
        check("t1_pend", pending_A, 1);
        tick(); #1;
        check("t1_pend_after", pending_A, 0);
        check("t1_we_after", ctrl_writeEnable, 0);

        // fill while the pipeline owns the port, then starve and drain in order
        for (int i = 0; i < 10; i++) begin
            tick();
            set_in(1, 20, 32'(32'h2000 + i), 1, 5'(i < 4 ? 10 + i : 14), 32'(32'h100 + i)); #1;
            check("t2_ready", md_ready, i < 4);
            check("t2_stall", pipe_stall, i == 9);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); set_in(0, 0, 0, 0, 0, 0); #1;
            check("t2_drain_we", ctrl_writeEnable, 1);
            check("t2_drain_reg", ctrl_writeReg, 5'(10 + i));
            check("t2_drain_data", data_writeReg, 32'(32'h100 + i));
        end

        // queued R7 overwritten by the pipeline
        tick(); set_in(0, 0, 0, 1, 7, 32'hAAAA); query_regA = 7; #1;
        tick(); set_in(1, 7, 32'hBBBB, 0, 0, 0); #1;
        check("t3_we", ctrl_writeEnable, 1);
        check("t3_data", data_writeReg, 32'hBBBB);
        check("t3_pend", pending_A, 1);
        tick(); set_in(0, 0, 0, 0, 0, 0); #1;
        check("t3_dead_we", ctrl_writeEnable, 0);
        check("t3_dead_pend", pending_A, 0);

        // two writes to R3 queued; youngest is forwarded
        tick(); set_in(1, 20, 32'h20, 1, 3, 32'h1); query_regA = 3; #1;
        tick(); set_in(1, 20, 32'h21, 1, 3, 32'h2); #1;
        tick(); set_in(1, 20, 32'h22, 0, 0, 0); #1;
        check("t4_pend", pending_A, 1);
`ifdef WBQ_BYPASS_EN
        check("t4_bvalid", bypass_valid_A, 1);
        check("t4_bdata", bypass_data_A, 32'h2);
`else
        check("t4_bvalid", bypass_valid_A, 0);
        check("t4_bdata", bypass_data_A, 32'h0);
`endif
        repeat (3) begin tick(); set_in(0, 0, 0, 0, 0, 0); end
        query_regA = 0;

        // register zero on both sources
        tick(); set_in(1, 0, 32'hDEAD, 1, 0, 32'hBEEF); #1;
        check("t5_ready", md_ready, 1);
        check("t5_we", ctrl_writeEnable, 0);
        tick(); set_in(0, 0, 0, 0, 0, 0); #1;
        check("t5_nothing", ctrl_writeEnable, 0);

        // reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            tick(); set_in(1, 20, 32'h30, 1, 5'(4 + i), 32'(32'h400 + i));
        end
        tick(); ctrl_reset = 1; set_in(1, 9, 32'h77, 0, 0, 0); query_regA = 4; query_regB = 6; #1;
        check("t6_rst_we", ctrl_writeEnable, 0);
        check("t6_rst_pend", pending_A, 0);
        tick(); ctrl_reset = 0; set_in(0, 0, 0, 0, 0, 0); #1;
        check("t6_ready", md_ready, 1);
        check("t6_pendA", pending_A, 0);
        check("t6_pendB", pending_B, 0);
        repeat (3) begin
            tick(); #1;
            check("t6_no_write", ctrl_writeEnable, 0);
        end

        tick(); #1;
        check("end_r7", obs_rf[7], 32'hBBBB);
        check("end_r5", obs_rf[5], 32'h1234);
        check("end_r4", obs_rf[4], 32'h0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
